// File: rtl/rv32_pkg.sv
// Shared RV32I front-end definitions: fetch FSM encoding, IF/ID slot layout
// and small address helpers used by the fetch stage.
package rv32_pkg;

    localparam int              XLEN       = 32;
    localparam logic [XLEN-1:0] NOP_INST   = 32'h0000_0013;
    localparam logic [XLEN-1:0] INST_BYTES = 32'd4;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DISCARD
    } fetch_state_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
    } if_id_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if_id_reg.sv
// IF/ID pipeline slot: holds one fetched instruction with its PC.
// Flush beats load beats drain; an empty slot always carries the fill word.
module if_id_reg
    import rv32_pkg::*;
#(
    parameter logic [XLEN-1:0] FILL_INST = NOP_INST
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_flush,
    input  logic            i_load,
    input  logic            i_ready,
    input  logic [XLEN-1:0] i_inst,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_pc_plus4,
    output if_id_t          o_slot
);

    if_id_t r_slot;
    logic   w_drain;

    assign w_drain = r_slot.valid && i_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_slot.valid    <= 1'b0;
            r_slot.inst     <= FILL_INST;
            r_slot.pc       <= '0;
            r_slot.pc_plus4 <= '0;
        end else if (i_flush) begin
            r_slot.valid <= 1'b0;
            r_slot.inst  <= FILL_INST;
        end else if (i_load) begin
            r_slot.valid    <= 1'b1;
            r_slot.inst     <= i_inst;
            r_slot.pc       <= i_pc;
            r_slot.pc_plus4 <= i_pc_plus4;
        end else if (w_drain) begin
            // PC fields keep their last value; only valid and the word are cleared.
            r_slot.valid <= 1'b0;
            r_slot.inst  <= FILL_INST;
        end
    end

    assign o_slot = r_slot;

endmodule

// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: PC register, single-outstanding instruction memory
// request FSM, redirect handling and the IF/ID slot feeding decode.
module instr_fetch_unit
    import rv32_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INST = rv32_pkg::NOP_INST
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            imem_valid,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            id_ready,
    output logic            id_valid,
    output logic [XLEN-1:0] id_inst,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc_plus4,
    output logic            misaligned_err,
    output fetch_state_t    dbg_state
);

    // Decode handshake: the slot content transfers when id_valid && id_ready
    // at a rising edge; id_* are held unchanged while id_valid && !id_ready.
    // Memory side: imem_req is a single-cycle pulse, imem_valid answers it
    // exactly once, and at most one request is ever in flight.

    fetch_state_t    r_state;
    fetch_state_t    w_next_state;
    logic [XLEN-1:0] r_pc;
    logic            r_misaligned;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_redirect_target;
    logic            w_slot_free;
    logic            w_issue;
    logic            w_capture;
    if_id_t          w_slot;

    assign w_pc_plus4        = r_pc + INST_BYTES;
    assign w_redirect_target = word_align(redirect_pc);
    assign w_slot_free       = !w_slot.valid || id_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_REQ: begin
                if (!redirect_valid && w_slot_free) begin
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_valid) begin
                    w_next_state = S_REQ;
                end else if (redirect_valid) begin
                    w_next_state = S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (imem_valid) begin
                    w_next_state = S_REQ;
                end
            end
            default: begin
                w_next_state = S_REQ;
            end
        endcase
    end

    // imem_req is gated by reset so it reads 0 for as long as reset is held.
    always_comb begin
        w_issue   = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            S_REQ: begin
                w_issue = reset && !redirect_valid && w_slot_free;
            end
            S_WAIT: begin
                w_capture = imem_valid && !redirect_valid;
            end
            default: begin
                w_issue   = 1'b0;
                w_capture = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= w_redirect_target;
        end else if (w_capture) begin
            r_pc <= w_pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_misaligned <= 1'b0;
        end else begin
            r_misaligned <= redirect_valid && is_misaligned(redirect_pc);
        end
    end

    if_id_reg #(
        .FILL_INST (NOP_INST)
    ) u_if_id (
        .clk        (clk),
        .reset      (reset),
        .i_flush    (redirect_valid),
        .i_load     (w_capture),
        .i_ready    (id_ready),
        .i_inst     (imem_rdata),
        .i_pc       (r_pc),
        .i_pc_plus4 (w_pc_plus4),
        .o_slot     (w_slot)
    );

    assign imem_req       = w_issue;
    assign imem_addr      = r_pc;
    assign id_valid       = w_slot.valid;
    assign id_inst        = w_slot.inst;
    assign id_pc          = w_slot.pc;
    assign id_pc_plus4    = w_slot.pc_plus4;
    assign misaligned_err = r_misaligned;
    assign dbg_state      = r_state;

    // A response with nothing outstanding means the memory broke protocol.
    a_no_stray_resp: assert property (@(posedge clk) disable iff (!reset)
        !(imem_valid && (r_state == S_REQ)));

    a_req_aligned: assert property (@(posedge clk) disable iff (!reset)
        !(imem_req && is_misaligned(r_pc)));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a memory responder with random wait states,
// a PC-stream reference model feeding an expected queue, and a slot monitor.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        misaligned_err;
    logic [1:0]  dbg_state;

    instr_fetch_unit #(
        .RESET_PC (RESET_PC),
        .NOP_INST (NOP)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .imem_valid     (imem_valid),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_inst        (id_inst),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .misaligned_err (misaligned_err),
        .dbg_state      (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int           n_checks;
    int           n_errors;
    logic [95:0]  exp_q[$];     // {pc, inst, pc_plus4}
    logic [31:0]  ref_pc;       // next PC the fetch stream should deliver
    int           cfg_wait_min;
    int           cfg_wait_max;
    bit           mem_busy;
    bit           mem_dropped;
    int           mem_cnt;
    logic [31:0]  mem_pend_addr;
    logic         exp_mis;
    int           starve;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        chk(name, 32'(act), 32'(exp));
    endtask

    task automatic check_reset_values(input string tag);
        chk_bit({tag, "_imem_req"}, imem_req, 1'b0);
        chk({tag, "_imem_addr"}, imem_addr, RESET_PC);
        chk_bit({tag, "_id_valid"}, id_valid, 1'b0);
        chk({tag, "_id_inst"}, id_inst, NOP);
        chk({tag, "_id_pc"}, id_pc, 32'h0);
        chk({tag, "_id_pc_plus4"}, id_pc_plus4, 32'h0);
        chk_bit({tag, "_misaligned"}, misaligned_err, 1'b0);
    endtask

    // Returns at the negedge of the first cycle with imem_req high.
    task automatic wait_req(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clk);
            seen = imem_req;
        end
        if (!seen) chk_bit({name, "_timeout"}, imem_req, 1'b1);
    endtask

    task automatic wait_valid(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clk);
            seen = id_valid;
        end
        if (!seen) chk_bit({name, "_timeout"}, id_valid, 1'b1);
    endtask

    task automatic pulse_redirect(input logic [31:0] target);
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc    = target;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
    endtask

    // ---------------- memory responder + reference model ----------------
    initial begin : mem_model
        imem_valid    = 1'b0;
        imem_rdata    = '0;
        ref_pc        = RESET_PC;
        mem_busy      = 1'b0;
        mem_dropped   = 1'b0;
        mem_cnt       = 0;
        mem_pend_addr = '0;
        forever begin
            @(negedge clk);
            imem_valid = 1'b0;
            imem_rdata = $urandom;
            if (!reset) begin
                mem_busy = 1'b0;
                exp_q.delete();
                ref_pc = RESET_PC;
            end else begin
                if (mem_busy) begin
                    chk_bit("req_while_outstanding", imem_req, 1'b0);
                    if (redirect_valid) mem_dropped = 1'b1;
                    if (mem_cnt == 0) begin
                        mem_busy   = 1'b0;
                        imem_valid = 1'b1;
                        imem_rdata = mem_word(mem_pend_addr);
                        if (!mem_dropped) begin
                            exp_q.push_back({ref_pc, mem_word(ref_pc), ref_pc + 32'd4});
                            ref_pc = ref_pc + 32'd4;
                        end
                    end else begin
                        mem_cnt--;
                    end
                end else if (imem_req) begin
                    chk("req_addr", imem_addr, ref_pc);
                    chk_bit("req_with_slot_stalled", id_valid && !id_ready, 1'b0);
                    chk_bit("req_in_redirect_cycle", redirect_valid && imem_req, 1'b0);
                    mem_busy      = 1'b1;
                    mem_dropped   = 1'b0;
                    mem_pend_addr = imem_addr;
                    mem_cnt       = int'($urandom_range(cfg_wait_max, cfg_wait_min));
                end
                if (redirect_valid) begin
                    ref_pc = redirect_pc & 32'hFFFF_FFFC;
                    exp_q.delete();
                end
            end
        end
    end

    // ---------------- slot monitor ----------------
    initial begin : monitor
        logic [95:0] e;
        exp_mis = 1'b0;
        starve  = 0;
        forever begin
            @(negedge clk);
            chk_bit("misaligned_err", misaligned_err, exp_mis);
            exp_mis = reset && redirect_valid && (redirect_pc[1:0] != 2'b00);
            if (!id_valid) chk("empty_slot_inst", id_inst, NOP);
            if (reset && !redirect_valid) begin
                if (id_valid) begin
                    starve = 0;
                    if (exp_q.size() == 0) begin
                        chk_bit("spurious_valid", id_valid, 1'b0);
                    end else begin
                        e = exp_q[0];
                        chk("id_pc", id_pc, e[95:64]);
                        chk("id_inst", id_inst, e[63:32]);
                        chk("id_pc_plus4", id_pc_plus4, e[31:0]);
                        if (id_ready) void'(exp_q.pop_front());
                    end
                end else if (exp_q.size() != 0) begin
                    starve++;
                    if (starve >= 3) begin
                        chk_bit("missing_valid", id_valid, 1'b1);
                        starve = 0;
                    end
                end
            end else begin
                starve = 0;
            end
        end
    end

    // ---------------- driver ----------------
    initial begin : driver
        n_checks       = 0;
        n_errors       = 0;
        cfg_wait_min   = 0;
        cfg_wait_max   = 0;
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_ready       = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("rst");

        // Reset release with zero wait states: req next cycle, data 2 cycles later.
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        chk_bit("first_req", imem_req, 1'b1);
        chk("first_addr", imem_addr, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk_bit("first_valid", id_valid, 1'b1);
        chk("first_pc", id_pc, 32'h0);
        chk("first_pc_plus4", id_pc_plus4, 32'h4);

        // Stall: slot frozen, no new request until id_ready rises.
        @(posedge clk); #1 id_ready = 1'b0;
        wait_valid("stall_valid");
        repeat (5) begin
            @(negedge clk);
            chk_bit("stall_no_req", imem_req, 1'b0);
            chk_bit("stall_hold_valid", id_valid, 1'b1);
        end
        @(posedge clk); #1 id_ready = 1'b1;
        @(negedge clk);
        chk_bit("unstall_req", imem_req, 1'b1);
        chk("unstall_addr", imem_addr, ref_pc);

        // Redirect while waiting on a 3-wait-state response.
        cfg_wait_min = 3;
        cfg_wait_max = 3;
        wait_req("rw_req");
        pulse_redirect(32'h0000_0100);
        wait_req("rw_req2");
        chk("rw_addr", imem_addr, 32'h0000_0100);
        chk_bit("rw_no_valid", id_valid, 1'b0);
        wait_valid("rw_valid");
        chk("rw_pc", id_pc, 32'h0000_0100);

        // Redirect in the same cycle as the response, consumer stalled.
        cfg_wait_min = 0;
        cfg_wait_max = 0;
        wait_req("co_req");
        @(posedge clk); #1;
        id_ready       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0180;
        @(posedge clk); #1 redirect_valid = 1'b0;
        wait_req("co_req2");
        chk("co_addr", imem_addr, 32'h0000_0180);
        chk_bit("co_flushed", id_valid, 1'b0);
        wait_valid("co_valid");
        chk("co_pc", id_pc, 32'h0000_0180);
        @(posedge clk); #1 id_ready = 1'b1;

        // Misaligned redirect: fetch aligned down, error pulse tracked by monitor.
        pulse_redirect(32'h0000_0203);
        wait_req("mis_req");
        chk("mis_addr", imem_addr, 32'h0000_0200);
        wait_valid("mis_valid");
        chk("mis_pc", id_pc, 32'h0000_0200);

        // Wrap-around past the top of the address space.
        pulse_redirect(32'hFFFF_FFFC);
        wait_valid("wrap_v1");
        chk("wrap_pc1", id_pc, 32'hFFFF_FFFC);
        chk("wrap_pc_plus4_1", id_pc_plus4, 32'h0);
        wait_valid("wrap_v2");
        chk("wrap_pc2", id_pc, 32'h0);
        chk("wrap_pc_plus4_2", id_pc_plus4, 32'h4);

        // Reset in the middle of an outstanding fetch.
        cfg_wait_min = 2;
        cfg_wait_max = 2;
        wait_req("mid_req");
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_values("midrst");
        @(posedge clk); #1 reset = 1'b1;
        wait_req("post_rst_req");
        chk("post_rst_addr", imem_addr, RESET_PC);

        // Randomized traffic: back-pressure, wait states, redirects.
        cfg_wait_min = 0;
        cfg_wait_max = 3;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            id_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) begin
                redirect_valid = 1'b1;
                case ($urandom_range(0, 3))
                    0:       redirect_pc = $urandom;
                    1:       redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                    default: redirect_pc = 32'($urandom_range(0, 255)) << 2;
                endcase
            end else begin
                redirect_valid = 1'b0;
            end
        end
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
